sd_sample_fetch: RTL and testbench
==================================

SD_SAMPLE_FETCH -- requirements
Module: sd_sample_fetch

Interface
REQ-001 SHALL have parameter START_SECTOR, default 0, first SD sector of the audio region.
REQ-002 SHALL have parameter NUM_SECTORS, default 4096, audio region length in 512-byte sectors; a multiple of 4, at least 4.
REQ-003 SHALL have port clock, input, 1, the single clock; same clock drives sd_controller and the sample buffer.
REQ-004 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-005 SHALL have port start, input, 1, one-cycle request to begin fetching from START_SECTOR.
REQ-006 SHALL have port sd_ready, input, 1, sd_controller idle and able to accept rd.
REQ-007 SHALL have port sd_byte_available, input, 1, sd_controller new-byte strobe.
REQ-008 SHALL have port sd_dout, input, 8, sd_controller read byte.
REQ-009 SHALL have port sd_rd, output, 1, read request to sd_controller.
REQ-010 SHALL have port sd_adr, output, 32, byte address of the sector being read.
REQ-011 SHALL have ports buf_en, buf_we, output, 1 each, sample_buffer port A enable and write enable.
REQ-012 SHALL have ports buf_addr, output, 10, and buf_din, output, 16, sample_buffer write address and data.
REQ-013 SHALL have port frame_ready, output, 1, high while 1024 new samples wait for the filter.
REQ-014 SHALL have port frame_ack, input, 1, filter consumed the frame.
REQ-015 SHALL have ports busy and done, output, 1 each, fetch in progress and region exhausted.

Function
REQ-016 SHALL implement FSM IDLE, WAIT_RDY, ISSUE, READ, FRAME_FULL, DONE.
REQ-017 SHALL, in IDLE, load sector counter to 0 and word address to 0 on start, then enter WAIT_RDY; start SHALL be ignored in every other state.
REQ-018 SHALL, in WAIT_RDY, enter ISSUE on the first cycle sd_ready is 1.
REQ-019 SHALL, in ISSUE, drive sd_rd=1 for exactly one cycle with sd_adr=(START_SECTOR+sector)*512, then enter READ; sd_adr SHALL hold stable until the next ISSUE.
REQ-020 SHALL count a byte only on a rising edge of sd_byte_available (previous-cycle sample 0, current 1), capturing sd_dout in that cycle.
REQ-021 SHALL assemble little-endian 16-bit samples: even byte into [7:0], odd byte into [15:8].
REQ-022 SHALL assert buf_en=buf_we=1 for one cycle, the cycle after the odd byte's edge, with buf_din=assembled sample and buf_addr=word address; the word address SHALL then increment modulo 1024.
REQ-023 SHALL, after the 512th byte of a sector, increment the sector counter and go to FRAME_FULL if the word address wrapped to 0, else WAIT_RDY.
REQ-024 SHALL, in FRAME_FULL, hold frame_ready=1 until frame_ack=1; on that cycle it SHALL clear frame_ready and enter DONE if sector==NUM_SECTORS, else WAIT_RDY.
REQ-025 SHALL ignore frame_ack outside FRAME_FULL.
REQ-026 SHALL drive busy=1 in all states except IDLE and DONE, and done=1 only in DONE; DONE SHALL return to IDLE on start.
REQ-027 SHALL ignore byte edges outside READ.

Reset
REQ-028 SHALL, on reset, enter IDLE and zero every output (sd_rd, sd_adr, buf_en, buf_we, buf_addr, buf_din, frame_ready, busy, done), counters, and the edge-detect register.
REQ-029 SHALL, on reset mid-read, abandon the sector; the next fetch SHALL still wait for sd_ready before issuing.

Configuration
REQ-030 SHALL honour macro SD_SAMPLE_FETCH_LOOP_EN: defined, reaching sector==NUM_SECTORS in REQ-024 SHALL reset sector to 0 and enter WAIT_RDY (continuous playback, done never asserted); undefined, behaviour is as REQ-024.

Verification
REQ-031 SHALL check: START_SECTOR=2, start, sd_ready=1 -> one-cycle sd_rd with sd_adr=0x400, busy=1.
REQ-032 SHALL check: bytes 0x34,0x12 -> one write, buf_addr=0, buf_din=0x1234, one cycle after the 0x12 edge.
REQ-033 SHALL check: sd_byte_available held high 3 cycles with one byte -> exactly one byte counted.
REQ-034 SHALL check: 4 full sectors -> 1024 writes, addresses 0..1023, frame_ready=1, no sd_rd until frame_ack.
REQ-035 SHALL check: NUM_SECTORS=4, frame_ack -> done=1, busy=0; with SD_SAMPLE_FETCH_LOOP_EN -> sd_adr returns to START_SECTOR*512.
REQ-036 SHALL check: reset asserted after 100 bytes -> all outputs 0 next cycle; new start reissues sector 0.

Source files
------------

// File: rtl/sd_sample_fetch.sv
// Streams the audio region off the SD card into the 1024-word sample buffer, one frame at a time (SD_SAMPLE_FETCH_LOOP_EN: wrap and replay forever).
// Latency: sd_rd one cycle after sd_ready is seen; each sample is written the cycle after its odd byte's strobe edge.
// Backpressure: waits on sd_ready before every sector and parks in FRAME_FULL until frame_ack.
module sd_sample_fetch #(
  parameter int START_SECTOR = 0,
  parameter int NUM_SECTORS  = 4096
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic        sd_ready,
  input  logic        sd_byte_available,
  input  logic [7:0]  sd_dout,
  output logic        sd_rd,
  output logic [31:0] sd_adr,
  output logic        buf_en,
  output logic        buf_we,
  output logic [9:0]  buf_addr,
  output logic [15:0] buf_din,
  output logic        frame_ready,
  input  logic        frame_ack,
  output logic        busy,
  output logic        done
);

  localparam int SW = $clog2(NUM_SECTORS + 1);

  typedef enum logic [2:0] {IDLE, WAIT_RDY, ISSUE, READ, FRAME_FULL, DONE} state_t;

  state_t        state, state_nxt;
  logic [SW-1:0] sector;
  logic [9:0]    word_addr;
  logic [8:0]    byte_cnt;
  logic [7:0]    lo_byte;
  logic          bav_q;
  logic          byte_edge;
  logic          sector_end;
  logic          last_sector;

  // A strobe held high for several cycles is still one byte.
  assign byte_edge   = (state == READ) && sd_byte_available && !bav_q;
  assign sector_end  = byte_edge && (byte_cnt == 9'd511);
  assign last_sector = (sector == SW'(NUM_SECTORS));

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    sd_rd       = 1'b0;
    frame_ready = 1'b0;
    busy        = 1'b1;
    done        = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) state_nxt = WAIT_RDY;
      end
      WAIT_RDY: begin
        if (sd_ready) state_nxt = ISSUE;
      end
      ISSUE: begin
        sd_rd     = 1'b1;
        state_nxt = READ;
      end
      READ: begin
        // The frame is full exactly when this byte's word lands in the last slot.
        if (sector_end) state_nxt = (word_addr == 10'd1023) ? FRAME_FULL : WAIT_RDY;
      end
      FRAME_FULL: begin
        frame_ready = 1'b1;
        if (frame_ack) begin
`ifdef SD_SAMPLE_FETCH_LOOP_EN
          state_nxt = WAIT_RDY;
`else
          state_nxt = last_sector ? DONE : WAIT_RDY;
`endif
        end
      end
      DONE: begin
        busy = 1'b0;
        done = 1'b1;
        if (start) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      sector    <= '0;
      word_addr <= '0;
      byte_cnt  <= '0;
      lo_byte   <= '0;
      bav_q     <= 1'b0;
      sd_adr    <= '0;
      buf_en    <= 1'b0;
      buf_we    <= 1'b0;
      buf_addr  <= '0;
      buf_din   <= '0;
    end else begin
      bav_q  <= sd_byte_available;
      buf_en <= 1'b0;
      buf_we <= 1'b0;

      if (state == IDLE && start) begin
        sector    <= '0;
        word_addr <= '0;
        byte_cnt  <= '0;
      end

      if (state == WAIT_RDY && sd_ready)
        sd_adr <= (32'(START_SECTOR) + 32'(sector)) << 9;

      if (byte_edge) begin
        byte_cnt <= byte_cnt + 9'd1;
        if (!byte_cnt[0]) begin
          lo_byte <= sd_dout;
        end else begin
          buf_en    <= 1'b1;
          buf_we    <= 1'b1;
          buf_din   <= {sd_dout, lo_byte};
          buf_addr  <= word_addr;
          word_addr <= word_addr + 10'd1;
        end
        if (sector_end) sector <= sector + SW'(1);
      end

`ifdef SD_SAMPLE_FETCH_LOOP_EN
      if (state == FRAME_FULL && frame_ack && last_sector) sector <= '0;
`endif
    end
  end

endmodule

// File: tb/tb_sd_sample_fetch.sv
// Bench for sd_sample_fetch: acts as the sd_controller, models expected sample writes as a queue.
module tb_sd_sample_fetch;

  localparam int START = 2;
  localparam int NSEC  = 4;

  logic        clock = 1'b0;
  logic        reset, start, sd_ready, sd_byte_available, frame_ack;
  logic [7:0]  sd_dout;
  logic        sd_rd, buf_en, buf_we, frame_ready, busy, done;
  logic [31:0] sd_adr;
  logic [9:0]  buf_addr;
  logic [15:0] buf_din;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          n_wr    = 0;
  int          exp_total = 0;
  int          samp_idx = 0;
  bit          odd_model = 1'b0;
  logic [7:0]  lo_model = 8'h00;
  logic [25:0] exp_q[$];
  logic [25:0] mon_e;
  bit          seen_rd;

  sd_sample_fetch #(.START_SECTOR(START), .NUM_SECTORS(NSEC)) dut (
    .clock(clock), .reset(reset), .start(start), .sd_ready(sd_ready),
    .sd_byte_available(sd_byte_available), .sd_dout(sd_dout), .sd_rd(sd_rd),
    .sd_adr(sd_adr), .buf_en(buf_en), .buf_we(buf_we), .buf_addr(buf_addr),
    .buf_din(buf_din), .frame_ready(frame_ready), .frame_ack(frame_ack),
    .busy(busy), .done(done)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Reference: consecutive bytes pair up little-endian; sample n goes to slot n mod 1024.
  task automatic model_byte(input logic [7:0] b);
    if (odd_model) begin
      exp_q.push_back({10'(samp_idx % 1024), b, lo_model});
      samp_idx++;
      exp_total++;
    end else begin
      lo_model = b;
    end
    odd_model = !odd_model;
  endtask

  task automatic model_restart();
    samp_idx  = 0;
    odd_model = 1'b0;
    lo_model  = 8'h00;
  endtask

  task automatic drive_byte(input logic [7:0] b, input int hold, input int gap);
    model_byte(b);
    sd_dout = b;
    sd_byte_available = 1'b1;
    repeat (hold) tick();
    sd_byte_available = 1'b0;
    repeat (gap) tick();
  endtask

  // The last byte of a sector uses the shortest strobe so the next sd_rd pulse is not stepped over.
  task automatic rand_bytes(input int n, input bit end_sector);
    for (int i = 0; i < n; i++) begin
      if (end_sector && i == n - 1) drive_byte(8'($urandom), 1, 1);
      else drive_byte(8'($urandom), int'($urandom_range(3, 1)), int'($urandom_range(2, 1)));
    end
  endtask

  task automatic wait_rd(input string tag);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      if (sd_rd === 1'b1) seen = 1'b1;
      else tick();
    end
    chk(tag, 32'(seen), 32'd1);
  endtask

  task automatic serve_sector(input int sec);
    wait_rd($sformatf("rd_seen_s%0d", sec));
    chk($sformatf("adr_s%0d", sec), sd_adr, 32'((START + sec) * 512));
    tick();
    chk($sformatf("rd_pulse_s%0d", sec), 32'(sd_rd), 32'd0);
    rand_bytes(512, 1'b1);
  endtask

  task automatic chk_all_zero(input string pfx);
    chk({pfx, "_sd_rd"},       32'(sd_rd),       32'd0);
    chk({pfx, "_sd_adr"},      sd_adr,           32'd0);
    chk({pfx, "_buf_en"},      32'(buf_en),      32'd0);
    chk({pfx, "_buf_we"},      32'(buf_we),      32'd0);
    chk({pfx, "_buf_addr"},    32'(buf_addr),    32'd0);
    chk({pfx, "_buf_din"},     32'(buf_din),     32'd0);
    chk({pfx, "_frame_ready"}, 32'(frame_ready), 32'd0);
    chk({pfx, "_busy"},        32'(busy),        32'd0);
    chk({pfx, "_done"},        32'(done),        32'd0);
  endtask

  // Every buffer write must match the head of the expected-sample queue.
  always @(negedge clock) begin
    if (reset === 1'b0 && buf_en === 1'b1) begin
      n_wr++;
      if (exp_q.size() == 0) begin
        chk("wr_unexpected", 32'(n_wr), 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        chk("wr_we",   32'(buf_we),   32'd1);
        chk("wr_addr", 32'(buf_addr), 32'(mon_e[25:16]));
        chk("wr_din",  32'(buf_din),  32'(mon_e[15:0]));
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; start = 1'b0; sd_ready = 1'b0; sd_byte_available = 1'b0;
    sd_dout = 8'h00; frame_ack = 1'b0;
    model_restart();
    repeat (3) tick();
    chk_all_zero("rst");

    reset = 1'b0;
    tick();
    chk("idle_busy", 32'(busy), 32'd0);
    start = 1'b1; tick(); start = 1'b0;
    chk("start_busy", 32'(busy), 32'd1);
    chk("start_done", 32'(done), 32'd0);
    repeat (3) tick();
    chk("wait_no_rd", 32'(sd_rd), 32'd0);

    sd_ready = 1'b1;
    tick();
    chk("issue_rd",   32'(sd_rd), 32'd1);
    chk("issue_adr",  sd_adr,     32'h400);
    chk("issue_busy", 32'(busy),  32'd1);
    tick();
    chk("rd_one_cycle", 32'(sd_rd), 32'd0);
    chk("adr_hold",     sd_adr,     32'h400);

    drive_byte(8'h34, 1, 1);
    model_byte(8'h12);
    sd_dout = 8'h12; sd_byte_available = 1'b1;
    tick();
    chk("w0_en",   32'(buf_en),   32'd1);
    chk("w0_we",   32'(buf_we),   32'd1);
    chk("w0_addr", 32'(buf_addr), 32'd0);
    chk("w0_din",  32'(buf_din),  32'h1234);
    sd_byte_available = 1'b0;
    tick();
    chk("w0_once", 32'(buf_en), 32'd0);

    drive_byte(8'h5a, 3, 1);
    drive_byte(8'hc3, 1, 1);
    rand_bytes(507, 1'b0);
    sd_ready = 1'b0;
    drive_byte(8'($urandom), 1, 1);
    chk("s0_end_no_rd", 32'(sd_rd), 32'd0);
    chk("s0_end_busy",  32'(busy),  32'd1);

    repeat (3) begin
      sd_byte_available = 1'b1; tick();
      sd_byte_available = 1'b0; tick();
    end
    frame_ack = 1'b1; tick(); frame_ack = 1'b0;
    chk("stray_no_rd", 32'(sd_rd), 32'd0);
    chk("stray_no_fr", 32'(frame_ready), 32'd0);
    sd_ready = 1'b1;

    serve_sector(1);
    serve_sector(2);
    serve_sector(3);
    chk("ff_frame_ready", 32'(frame_ready), 32'd1);
    chk("ff_busy",        32'(busy),        32'd1);
    chk("ff_writes",      32'(n_wr),        32'd1024);
    chk("ff_q_empty",     32'(exp_q.size()), 32'd0);
    seen_rd = 1'b0;
    repeat (20) begin
      tick();
      if (sd_rd === 1'b1) seen_rd = 1'b1;
    end
    chk("ff_no_rd",   32'(seen_rd),     32'd0);
    chk("ff_hold",    32'(frame_ready), 32'd1);

    frame_ack = 1'b1; tick(); frame_ack = 1'b0;
    chk("ack_clear", 32'(frame_ready), 32'd0);
    model_restart();
`ifdef SD_SAMPLE_FETCH_LOOP_EN
    chk("loop_done", 32'(done), 32'd0);
    chk("loop_busy", 32'(busy), 32'd1);
    wait_rd("loop_rd");
    chk("loop_adr", sd_adr, 32'h400);
    tick();
`else
    chk("done",      32'(done), 32'd1);
    chk("done_busy", 32'(busy), 32'd0);
    repeat (3) tick();
    chk("done_hold", 32'(done), 32'd1);
    start = 1'b1; tick(); start = 1'b0;
    chk("done_to_idle", 32'(done), 32'd0);
    chk("idle_again",   32'(busy), 32'd0);
    start = 1'b1; tick(); start = 1'b0;
    chk("refetch_busy", 32'(busy), 32'd1);
    wait_rd("refetch_rd");
    chk("refetch_adr", sd_adr, 32'h400);
    tick();
`endif

    rand_bytes(100, 1'b0);
    chk("pre_rst_q", 32'(exp_q.size()), 32'd0);
    reset = 1'b1;
    tick();
    chk_all_zero("midrst");
    reset = 1'b0;
    model_restart();
    exp_q.delete();
    sd_ready = 1'b0;
    tick();
    start = 1'b1; tick(); start = 1'b0;
    repeat (4) tick();
    chk("post_rst_wait", 32'(sd_rd), 32'd0);
    chk("post_rst_busy", 32'(busy),  32'd1);
    sd_ready = 1'b1;
    wait_rd("post_rst_rd");
    chk("post_rst_adr", sd_adr, 32'h400);
    tick();
    rand_bytes(6, 1'b0);
    tick();
    chk("total_writes", 32'(n_wr),         32'(exp_total));
    chk("final_q",      32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
